// File: rtl/dma_axil_pkg.sv
// Shared constants for the DMA AXI4-Lite register slave: register offsets,
// CTRL/STATUS bit positions and AXI response codes.
package dma_axil_pkg;

  localparam logic [31:0] OFF_CTRL   = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFF_SRC    = 32'h0000_0018;
  localparam logic [31:0] OFF_LEN    = 32'h0000_0028;

  localparam int CTRL_RS       = 0;
  localparam int CTRL_SOFT_RST = 2;
  localparam int CTRL_IOC_EN   = 12;

  localparam int STATUS_HALTED = 0;
  localparam int STATUS_IDLE   = 1;
  localparam int STATUS_IOC    = 12;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_wr_capture.sv
// AXI4-Lite write-side front end: independent AW/W hold registers, ready
// generation and a single-cycle commit strobe once address and data are both available.
module axil_wr_capture #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [31:0]       wdata_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic              bvalid_i,
  output logic              commit_o,
  output logic [ADDR_W-1:0] commit_addr_o,
  output logic [31:0]       commit_data_o
);

  logic              aw_held_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic              w_held_q;
  logic [31:0]       w_data_q;
  logic              aw_hs_s;
  logic              w_hs_s;

  assign awready_o     = ~aw_held_q & ~bvalid_i;
  assign wready_o      = ~w_held_q & ~bvalid_i;
  assign aw_hs_s       = awvalid_i & awready_o;
  assign w_hs_s        = wvalid_i & wready_o;
  assign commit_o      = (aw_held_q | aw_hs_s) & (w_held_q | w_hs_s);
  assign commit_addr_o = aw_held_q ? aw_addr_q : awaddr_i;
  assign commit_data_o = w_held_q ? w_data_q : wdata_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= 32'h0;
    end else if (commit_o) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= awaddr_i;
      end
      if (w_hs_s) begin
        w_held_q <= 1'b1;
        w_data_q <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/dma_axil_reg_slave.sv
// DMA config/status register block behind an AXI4-Lite slave port.
// Define DMA_AXIL_READ_EN to build the register read mux; otherwise reads return 0 with SLVERR.
module dma_axil_reg_slave
  import dma_axil_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic [31:0]       dma_src_addr,
  output logic [LEN_W-1:0]  dma_len,
  output logic              dma_start,
  input  logic              dma_done,
  output logic              irq
);

  logic              rs_q, rs_d, ioc_en_q, ioc_en_d, ioc_q, ioc_d, busy_q, busy_d;
  logic              start_q, start_d, irq_q, irq_d;
  logic [31:0]       src_q, src_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              wr_commit_s, wr_ok_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [31:0]       wr_data_s, wr_off_s;
  logic [31:0]       rd_data_s;
  logic [1:0]        rd_resp_s;

  axil_wr_capture #(.ADDR_W(ADDR_W)) u_wr_capture (
    .clk           (clk),
    .rst           (rst),
    .awaddr_i      (s_axil_awaddr),
    .awvalid_i     (s_axil_awvalid),
    .awready_o     (s_axil_awready),
    .wdata_i       (s_axil_wdata),
    .wvalid_i      (s_axil_wvalid),
    .wready_o      (s_axil_wready),
    .bvalid_i      (bvalid_q),
    .commit_o      (wr_commit_s),
    .commit_addr_o (wr_addr_s),
    .commit_data_o (wr_data_s)
  );

  assign wr_off_s = {{(32-ADDR_W){1'b0}}, wr_addr_s};

`ifdef DMA_AXIL_READ_EN
  logic [31:0] rd_off_s;
  assign rd_off_s = {{(32-ADDR_W){1'b0}}, s_axil_araddr};

  // Register read mux; anything not on an aligned mapped offset is an error
  always_comb begin
    rd_data_s = 32'h0;
    rd_resp_s = RESP_OKAY;
    case (rd_off_s)
      OFF_CTRL: begin
        rd_data_s[CTRL_RS]     = rs_q;
        rd_data_s[CTRL_IOC_EN] = ioc_en_q;
      end
      OFF_STATUS: begin
        rd_data_s[STATUS_HALTED] = ~rs_q;
        rd_data_s[STATUS_IDLE]   = ~busy_q;
        rd_data_s[STATUS_IOC]    = ioc_q;
      end
      OFF_SRC: rd_data_s = src_q;
      OFF_LEN: rd_data_s[LEN_W-1:0] = len_q;
      default: rd_resp_s = RESP_SLVERR;
    endcase
  end
`else
  logic unused_araddr_s;
  assign unused_araddr_s = ^s_axil_araddr;
  assign rd_data_s = 32'h0;
  assign rd_resp_s = RESP_SLVERR;
`endif

  // Next-state: write decode, completion, soft reset and channel handshakes
  always_comb begin
    rs_d     = rs_q;
    ioc_en_d = ioc_en_q;
    ioc_d    = ioc_q;
    busy_d   = busy_q;
    src_d    = src_q;
    len_d    = len_q;
    start_d  = 1'b0;
    wr_ok_s  = 1'b0;
    if (wr_commit_s && (wr_addr_s[1:0] == 2'b00)) begin
      case (wr_off_s)
        OFF_CTRL: begin
          wr_ok_s  = 1'b1;
          rs_d     = wr_data_s[CTRL_RS];
          ioc_en_d = wr_data_s[CTRL_IOC_EN];
        end
        OFF_STATUS: begin
          wr_ok_s = 1'b1;
          if (wr_data_s[STATUS_IOC]) ioc_d = 1'b0;
          else                       ioc_d = ioc_q;
        end
        OFF_SRC: begin
          wr_ok_s = 1'b1;
          src_d   = wr_data_s;
        end
        OFF_LEN: begin
          if (!busy_q) begin
            wr_ok_s = 1'b1;
            len_d   = wr_data_s[LEN_W-1:0];
            if (rs_q && (wr_data_s[LEN_W-1:0] != '0)) begin
              start_d = 1'b1;
              busy_d  = 1'b1;
            end else begin
              start_d = 1'b0;
            end
          end else begin
            wr_ok_s = 1'b0;
          end
        end
        default: wr_ok_s = 1'b0;
      endcase
    end else begin
      wr_ok_s = 1'b0;
    end
    // Completion is applied after the W1C so a same-cycle set wins
    if (dma_done && busy_q) begin
      busy_d = 1'b0;
      ioc_d  = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    if (wr_ok_s && (wr_off_s == OFF_CTRL) && wr_data_s[CTRL_SOFT_RST]) begin
      rs_d     = 1'b0;
      ioc_en_d = 1'b0;
      src_d    = 32'h0;
      len_d    = '0;
      ioc_d    = 1'b0;
      busy_d   = 1'b0;
      start_d  = 1'b0;
    end else begin
      rs_d = rs_d;
    end
    irq_d = ioc_d & ioc_en_d;

    if (wr_commit_s) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end else begin
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
    end

    if (s_axil_arvalid && !rvalid_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data_s;
      rresp_d  = rd_resp_s;
    end else if (rvalid_q && s_axil_rready) begin
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
    end else begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q     <= 1'b0;
      ioc_en_q <= 1'b0;
      ioc_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
      src_q    <= 32'h0;
      len_q    <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= 32'h0;
    end else begin
      rs_q     <= rs_d;
      ioc_en_q <= ioc_en_d;
      ioc_q    <= ioc_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      irq_q    <= irq_d;
      src_q    <= src_d;
      len_q    <= len_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = ~rvalid_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign dma_src_addr   = src_q;
  assign dma_len        = len_q;
  assign dma_start      = start_q;
  assign irq            = irq_q;

endmodule
